// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
//
// APB completer backed by a small word-addressed register memory. The slave
// latches the address, direction and write data in the setup phase. It then
// completes the transfer in the access phase, with optional wait states.
// Out-of-range addresses complete with pslverr. Errored writes never touch
// the memory, and errored reads return zero.
//
// Optional feature macro: APB_SLV_WAIT_EN
//   defined   : each transfer inserts WAIT_CYCLES wait states.
//   undefined : there is no counter logic and every transfer is zero-wait.
//
// Ports:
//   top_clk  in   sole clock; all state changes on its rising edge
//   prst     in   asynchronous active-low reset (clears the memory as well)
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwr      in   1 = write, 0 = read
//   padd     in   word address        [ADD_WIDTH-1:0]
//   pwdata   in   write data          [DATA_WIDTH-1:0]
//   prdata   out  read data, zero unless a good read completes
//   pslverr  out  error response, only while pready is high
//   pready   out  transfer completion
// ---------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADD_WIDTH   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  top_clk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwr,
  input  logic [ADD_WIDTH-1:0]  padd,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  pready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADD_WIDTH:0] DEPTH_LIM = DEPTH[ADD_WIDTH:0];

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADD_WIDTH-1:0]    addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    setup_take;
  logic                    cnt_zero;
  logic                    wr_en;
  logic [IDX_W-1:0]        addr_idx;
  logic                    unused_addr;

  // A setup phase is only recognised from IDLE. A penable=1 seen in IDLE
  // is a stray access with no setup, so it is ignored.
  assign setup_take = (state_q == IDLE) && psel && !penable;

  // Only the low index bits address the memory. The full address is still
  // range-checked at latch time, so the upper bits never select a word.
  assign addr_idx    = addr_q[IDX_W-1:0];
  assign unused_addr = ^addr_q;

  // The write commits on the edge that ends the pready cycle. Errored and
  // aborted transfers never reach this point.
  assign wr_en = pready && wr_q && !err_q;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  // The wait counter is loaded at setup. It counts down through the access
  // phase, and pready can only rise once it has reached zero.
  always_comb begin
    cnt_d = cnt_q;
    if (setup_take) begin
      cnt_d = WAIT_CYCLES[3:0];
    end else if ((state_q == ACCESS) && psel && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge top_clk or negedge prst) begin
    if (!prst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == 4'd0);
`else
  logic [31:0] unused_wait;

  assign unused_wait = WAIT_CYCLES;
  assign cnt_zero    = 1'b1;
`endif

  // State register
  always_ff @(posedge top_clk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Dropping psel during ACCESS abandons the transfer.
  // A completed transfer always passes back through IDLE, so a new setup
  // is never accepted in the pready cycle itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup_take) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel || pready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pready  = (state_q == ACCESS) && cnt_zero && psel && penable;
    pslverr = pready && err_q;
    prdata  = '0;
    if (pready && !wr_q && !err_q) begin
      prdata = mem_q[addr_idx];
    end
  end

  // The setup-phase latches are the only view of the request that the
  // access phase uses. Later changes on the bus therefore have no effect.
  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (setup_take) begin
      addr_d  = padd;
      wr_d    = pwr;
      wdata_d = pwdata;
      err_d   = ({1'b0, padd} >= DEPTH_LIM);
    end
  end

  always_ff @(posedge top_clk or negedge prst) begin
    if (!prst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Memory array. Reset clears every word, so a write still pending when
  // reset arrives is lost.
  always_ff @(posedge top_clk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed testbench for apb_slave_mem. The driver works on the falling
// edge and the DUT works on the rising edge. Outputs are sampled 1ns after
// the falling edge, well away from the active edge.
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        top_clk;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwr;
  logic [7:0]  padd;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;

  int total;
  int bad;

  apb_slave_mem #(
    .ADD_WIDTH   (8),
    .DATA_WIDTH  (32),
    .DEPTH       (16),
    .WAIT_CYCLES (2)
  ) dut (
    .top_clk (top_clk),
    .prst    (prst),
    .psel    (psel),
    .penable (penable),
    .pwr     (pwr),
    .padd    (padd),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pslverr (pslverr),
    .pready  (pready)
  );

  // Free-running clock: rising edges at 5, 15, 25 ... and falling edges at 10, 20 ...
  initial begin
    top_clk = 1'b0;
    forever #5 top_clk = ~top_clk;
  end

  // Single comparison point. It counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete APB transfer. The setup phase is driven on the next falling
  // edge, followed by the access phase until pready is seen. The bus is left
  // in the access phase afterwards, so the caller can start the next transfer
  // back-to-back or park the bus with idleBus.
  task automatic applyStimulus(input logic isWrite, input logic [7:0] addr,
                               input logic [31:0] data,
                               output logic [31:0] rdata, output logic err,
                               output int cycles);
    @(negedge top_clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwr     = isWrite;
    padd    = addr;
    pwdata  = data;
    cycles  = 1;
    #1;
    checkOutput("setup_pready", {31'b0, pready}, 32'd0);
    @(negedge top_clk);
    penable = 1'b1;
    cycles  = 2;
    #1;
    for (int k = 0; k < 20 && !pready; k++) begin
      @(negedge top_clk);
      cycles++;
      #1;
    end
    checkOutput("pready_seen", {31'b0, pready}, 32'd1);
    rdata = prdata;
    err   = pslverr;
  endtask

  task automatic idleBus();
    @(negedge top_clk);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    total   = 0;
    bad     = 0;
    prst    = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwr     = 1'b0;
    padd    = 8'd0;
    pwdata  = 32'd0;

    // Reset state
    #12;
    checkOutput("rst_pready", {31'b0, pready}, 32'd0);
    checkOutput("rst_pslverr", {31'b0, pslverr}, 32'd0);
    checkOutput("rst_prdata", prdata, 32'd0);
    @(negedge top_clk);
    prst = 1'b1;

    // Write then read addr 3, back-to-back
    applyStimulus(1'b1, 8'd3, 32'hDEADBEEF, rd, er, cyc);
    checkOutput("wr3_err", {31'b0, er}, 32'd0);
    checkOutput("wr3_cycles", cyc, 2 + EXP_WAIT);
    applyStimulus(1'b0, 8'd3, 32'h0, rd, er, cyc);
    checkOutput("rd3_data", rd, 32'hDEADBEEF);
    checkOutput("rd3_err", {31'b0, er}, 32'd0);
    checkOutput("rd3_cycles", cyc, 2 + EXP_WAIT);

    // After completion, penable held high with no new setup must not
    // produce a second pready.
    for (int k = 0; k < 3; k++) begin
      @(negedge top_clk);
      psel    = 1'b1;
      penable = 1'b1;
      #1;
      checkOutput("no_setup_pready", {31'b0, pready}, 32'd0);
    end
    idleBus();

    // Out-of-range read and write. Address 20 aliases word 4 in its low bits.
    applyStimulus(1'b0, 8'd20, 32'h0, rd, er, cyc);
    checkOutput("rd20_err", {31'b0, er}, 32'd1);
    checkOutput("rd20_data", rd, 32'd0);
    applyStimulus(1'b1, 8'd20, 32'h1234, rd, er, cyc);
    checkOutput("wr20_err", {31'b0, er}, 32'd1);
    applyStimulus(1'b0, 8'd4, 32'h0, rd, er, cyc);
    checkOutput("rd4_data", rd, 32'd0);
    checkOutput("rd4_err", {31'b0, er}, 32'd0);
    idleBus();

    // Wait-state timing on a write to addr 1
    applyStimulus(1'b1, 8'd1, 32'hA5A5_0001, rd, er, cyc);
    checkOutput("wr1_cycles", cyc, 2 + EXP_WAIT);
    applyStimulus(1'b0, 8'd1, 32'h0, rd, er, cyc);
    checkOutput("rd1_data", rd, 32'hA5A5_0001);
    idleBus();

    // Abort: setup a write of 0x55 to addr 2, then drop psel during ACCESS
    @(negedge top_clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwr     = 1'b1;
    padd    = 8'd2;
    pwdata  = 32'h55;
    @(negedge top_clk);
    psel    = 1'b0;
    penable = 1'b0;
    #1;
    checkOutput("abort_pready", {31'b0, pready}, 32'd0);
    applyStimulus(1'b0, 8'd2, 32'h0, rd, er, cyc);
    checkOutput("rd2_after_abort", rd, 32'd0);
    idleBus();

    // Reset during the access phase of a write of 0xFF to addr 5
    @(negedge top_clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwr     = 1'b1;
    padd    = 8'd5;
    pwdata  = 32'hFF;
    @(negedge top_clk);
    penable = 1'b1;
    #1;
    checkOutput("pre_rst_pready", {31'b0, pready}, (EXP_WAIT == 0) ? 32'd1 : 32'd0);
    prst = 1'b0;
    #1;
    checkOutput("mid_rst_pready", {31'b0, pready}, 32'd0);
    checkOutput("mid_rst_pslverr", {31'b0, pslverr}, 32'd0);
    checkOutput("mid_rst_prdata", prdata, 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge top_clk);
    prst = 1'b1;
    applyStimulus(1'b0, 8'd5, 32'h0, rd, er, cyc);
    checkOutput("rd5_after_rst", rd, 32'd0);
    applyStimulus(1'b0, 8'd3, 32'h0, rd, er, cyc);
    checkOutput("rd3_after_rst", rd, 32'd0);
    idleBus();

    // Normal operation still works after the reset
    applyStimulus(1'b1, 8'd15, 32'h0BAD_F00D, rd, er, cyc);
    checkOutput("wr15_err", {31'b0, er}, 32'd0);
    applyStimulus(1'b0, 8'd15, 32'h0, rd, er, cyc);
    checkOutput("rd15_data", rd, 32'h0BAD_F00D);
    idleBus();
    #1;
    checkOutput("idle_prdata", prdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
